uart_rx_frame_check: RTL
========================

Name: uart_rx_frame_check

Overview:
- Parametrised successor to the UART RX start-bit checker.
- Tracks a complete RX frame (start, data, optional parity, stop) from the per-bit sample strobe.
- Deserialises the data bits LSB first and flags start glitch, parity error and stop error.
- Keeps saturating error counters; sits between the RX data sampler and the RX output register.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- frame_start  input  1  one-cycle pulse: start edge detected; accepted only in IDLE.
- finish_s  input  1  one-cycle pulse: sampled_bit is valid for the current bit.
- sampled_bit  input  1  majority-sampled line value.
- par_en  input  1  parity bit present; latched at frame_start.
- par_typ  input  1  0 = even parity, 1 = odd parity; latched at frame_start.
- cnt_clr  input  1  synchronous clear of all error counters.
- rx_data  output  DATA_WIDTH  last good frame payload.
- data_valid  output  1  one-cycle pulse: rx_data updated.
- frame_done  output  1  one-cycle pulse: frame ended (good, errored or glitch-aborted).
- strt_glitch  output  1  level flag: start bit sampled high.
- par_err  output  1  level flag: parity mismatch in current/last frame.
- stp_err  output  1  level flag: a stop bit sampled low.
- glitch_cnt  output  CNT_WIDTH  count of start glitches.
- par_err_cnt  output  CNT_WIDTH  count of parity-error frames.
- stp_err_cnt  output  CNT_WIDTH  count of stop-error frames.

Behaviour:
- Reset (RST low, async): FSM goes to IDLE; every output, the shift register, bit counter and latched par_en/par_typ clear to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP. The FSM advances only on cycles with finish_s=1, except the IDLE->START transition.
- IDLE:
  - frame_start=1 -> START, latch par_en/par_typ, clear strt_glitch, par_err and stp_err.
  - A finish_s arriving in IDLE, or in the same cycle as frame_start, is ignored.
- START, on finish_s:
  - sampled_bit=1 -> strt_glitch=1, glitch_cnt+1, frame_done pulse, back to IDLE.
  - sampled_bit=0 -> DATA with bit_cnt=0.
- DATA, on finish_s:
  - Shift sampled_bit in at the MSB, shifting right (LSB first on the line); bit_cnt+1.
  - After bit DATA_WIDTH-1, go to PARITY if latched par_en=1, else go to STOP.
- PARITY, on finish_s:
  - expected = XOR(shift register) XOR latched par_typ.
  - sampled_bit != expected -> par_err=1. Go to STOP regardless of the result.
- STOP:
  - Each finish_s with sampled_bit=0 sets stp_err=1.
  - On the STOP_BITS-th stop strobe, in the cycle after that strobe:
    - Pulse frame_done.
    - Increment par_err_cnt if par_err is set and stp_err_cnt if stp_err is set; each counter increments at most once per frame.
    - If neither error is set, load rx_data and pulse data_valid.
  - Then return to IDLE.
- Errored frames never modify rx_data.
- frame_start outside IDLE is ignored; no re-sync mid-frame.
- Latency: data_valid and frame_done assert exactly 1 cycle after the final stop-bit finish_s, and 1 cycle after a glitched start-bit finish_s.
- Counters:
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - cnt_clr has priority over a same-cycle increment, so the result is 0.
- Flags hold their value until the next accepted frame_start.
- An asynchronous reset mid-frame aborts the frame; no frame_done is issued.

Test Plan:
- DATA_WIDTH=8, par_en=0, line start=0, data 0xA5 LSB first, stop=1 -> rx_data=0xA5, data_valid and frame_done pulse 1 cycle after stop strobe, all flags 0.
- par_en=1, par_typ=0, data 0x07, parity bit 1 -> par_err=0, rx_data=0x07. Same frame with parity bit 0 -> par_err=1, par_err_cnt=1, no data_valid, rx_data keeps 0x07.
- Start bit sampled 1 -> strt_glitch=1, glitch_cnt=1, frame_done pulse, FSM back in IDLE; next frame_start clears strt_glitch.
- STOP_BITS=2, data 0x3C, second stop bit sampled 0 -> stp_err=1, stp_err_cnt=1, no data_valid.
- CNT_WIDTH=2, 5 consecutive glitched starts -> glitch_cnt stays at 3. Asserting cnt_clr in the same cycle as a glitch increment -> glitch_cnt=0.
- Assert RST low during DATA bit 4 -> all outputs 0 immediately. Release RST, send a full frame with 0x5A -> rx_data=0x5A. frame_start pulsed mid-frame -> ignored.

Source files
------------

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check
// Tracks one UART RX frame (start, data, optional parity, stop bits) driven by the
// per-bit sample strobe. It deserialises the data LSB first, flags a start glitch,
// a parity error and a stop error, and keeps saturating per-error frame counters.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   frame_start         start-edge pulse; accepted only in idle
//   finish_s            sampled_bit is valid for the current bit
//   sampled_bit         majority-sampled line value
//   par_en, par_typ     parity present / odd parity; latched at frame_start
//   cnt_clr             synchronous clear of all error counters
//   rx_data             payload of the last good frame
//   data_valid          pulse: rx_data updated
//   frame_done          pulse: frame ended (good, errored or glitch-aborted)
//   strt_glitch         level: start bit sampled high
//   par_err             level: parity mismatch
//   stp_err             level: a stop bit sampled low
//   glitch_cnt, par_err_cnt, stp_err_cnt   saturating error counters
module uart_rx_frame_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  finish_s,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  cnt_clr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_valid,
  output logic                  frame_done,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [CNT_WIDTH-1:0]  glitch_cnt,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                  state_q, state_d;
  logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic                    strt_glitch_q, strt_glitch_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic [CNT_WIDTH-1:0]    glitch_cnt_q, glitch_cnt_d;
  logic [CNT_WIDTH-1:0]    par_err_cnt_q, par_err_cnt_d;
  logic [CNT_WIDTH-1:0]    stp_err_cnt_q, stp_err_cnt_d;
  logic                    glitch_inc, par_inc, stp_inc;
  logic                    last_stop;

  // With two stop bits, stop_cnt_q marks that the first one has been taken.
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt_q;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (frame_start) state_d = StStart;
      StStart:  if (finish_s) state_d = sampled_bit ? StIdle : StData;
      StData: begin
        if (finish_s && (bit_cnt_q == LastBit)) state_d = par_en_q ? StParity : StStop;
      end
      StParity: if (finish_s) state_d = StStop;
      StStop:   if (finish_s && last_stop) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath and output next-state logic
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    rx_data_d     = rx_data_q;
    data_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    strt_glitch_d = strt_glitch_q;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    glitch_inc    = 1'b0;
    par_inc       = 1'b0;
    stp_inc       = 1'b0;

    case (state_q)
      StIdle: begin
        if (frame_start) begin
          par_en_d      = par_en;
          par_typ_d     = par_typ;
          strt_glitch_d = 1'b0;
          par_err_d     = 1'b0;
          stp_err_d     = 1'b0;
          bit_cnt_d     = '0;
          stop_cnt_d    = 1'b0;
        end
      end
      StStart: begin
        if (finish_s) begin
          if (sampled_bit) begin
            strt_glitch_d = 1'b1;
            glitch_inc    = 1'b1;
            frame_done_d  = 1'b1;
          end else begin
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (finish_s) begin
          // LSB arrives first, so shifting right leaves it at bit 0.
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (finish_s && (sampled_bit != ((^shift_q) ^ par_typ_q))) par_err_d = 1'b1;
      end
      StStop: begin
        if (finish_s) begin
          if (!sampled_bit) stp_err_d = 1'b1;
          stop_cnt_d = 1'b1;
          if (last_stop) begin
            // stp_err_d already includes the final stop bit's own sample.
            frame_done_d = 1'b1;
            par_inc      = par_err_q;
            stp_inc      = stp_err_d;
            if (!par_err_q && !stp_err_d) begin
              rx_data_d    = shift_q;
              data_valid_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    // Saturating counters; clear wins over a same-cycle increment.
    glitch_cnt_d = glitch_cnt_q;
    if (cnt_clr) glitch_cnt_d = '0;
    else if (glitch_inc && (glitch_cnt_q != '1)) glitch_cnt_d = glitch_cnt_q + CNT_WIDTH'(1);

    par_err_cnt_d = par_err_cnt_q;
    if (cnt_clr) par_err_cnt_d = '0;
    else if (par_inc && (par_err_cnt_q != '1)) par_err_cnt_d = par_err_cnt_q + CNT_WIDTH'(1);

    stp_err_cnt_d = stp_err_cnt_q;
    if (cnt_clr) stp_err_cnt_d = '0;
    else if (stp_inc && (stp_err_cnt_q != '1)) stp_err_cnt_d = stp_err_cnt_q + CNT_WIDTH'(1);
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      shift_q       <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      rx_data_q     <= '0;
      data_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      glitch_cnt_q  <= '0;
      par_err_cnt_q <= '0;
      stp_err_cnt_q <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      shift_q       <= shift_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      rx_data_q     <= rx_data_d;
      data_valid_q  <= data_valid_d;
      frame_done_q  <= frame_done_d;
      strt_glitch_q <= strt_glitch_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      glitch_cnt_q  <= glitch_cnt_d;
      par_err_cnt_q <= par_err_cnt_d;
      stp_err_cnt_q <= stp_err_cnt_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign data_valid  = data_valid_q;
  assign frame_done  = frame_done_q;
  assign strt_glitch = strt_glitch_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign glitch_cnt  = glitch_cnt_q;
  assign par_err_cnt = par_err_cnt_q;
  assign stp_err_cnt = stp_err_cnt_q;

endmodule
